lut_bank: RTL and testbench
===========================

# lut_bank

Programmable bank of OUT_N truth-table functions over an IN_W-bit input vector. Generalises the team's fixed 4-input, 10-output function boards. Each function's truth table is loaded at runtime through a config handshake. Results come out through a registered valid/ready output, either per requested vector or via an automatic exhaustive sweep of all 2^IN_W inputs, so the ALU bring-up benches can dump the full truth table in hardware.

## Interface
- IN_W, 4, input vector width (1..8); table depth D = 2^IN_W
- OUT_N, 10, number of functions (1..32)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low
- cfg_valid  in  1  table write request
- cfg_ready  out  1  table write accepted when cfg_valid && cfg_ready
- cfg_func  in  5  function index to overwrite
- cfg_table  in  D  new truth table; bit k = output for input value k
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_func >= OUT_N (write dropped)
- in_valid  in  1  evaluation request
- in_ready  out  1  evaluation accepted when in_valid && in_ready
- in_vec  in  IN_W  input vector to evaluate
- sweep_start  in  1  pulse: begin exhaustive sweep (honoured only in IDLE)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result when out_valid && out_ready
- out_vec  out  OUT_N  bit j = table[j][out_idx]
- out_idx  out  IN_W  input vector that produced out_vec
- out_last  out  1  result is final element of a sweep
- busy  out  1  state != IDLE
- sweep_done  out  1  one-cycle pulse after last sweep result is consumed

## Operation
- Storage: OUT_N × D flop array; all bits reset to 0.
- States: IDLE, SWEEP, DONE.
- IDLE: cfg_ready = 1; in_ready = !out_valid || out_ready. sweep_start (with in_valid ignored that cycle, in_ready forced 0) loads counter = 0, → SWEEP. sweep_start while out_valid still held is still honoured; first sweep result waits for the slot.
- SWEEP: cfg_ready = 0, in_ready = 0. Each cycle the output slot is free (!out_valid || out_ready), issue counter value as a result; out_last = (counter == D-1). On issuing D-1 → DONE, else counter + 1. sweep_start ignored.
- DONE: waits until the last result is consumed (out_valid && out_ready && out_last), then pulses sweep_done and returns to IDLE on the same edge. cfg_ready = 0, in_ready = 0.
- Config write: table[cfg_func] ← cfg_table on accept edge; cfg_func >= OUT_N drops write and pulses cfg_err next cycle.
- Same-cycle config write and evaluation accept: evaluation uses the old table; new table visible from next cycle.
- out_vec is computed at issue and registered; later table writes never change a held result.
- Counter is IN_W+0 bits; no wrap beyond D-1 is possible because issue of D-1 leaves SWEEP.
- Reset mid-operation: immediate return to IDLE, out_valid = 0, tables cleared, no sweep_done.

## Timing
- Reset values: cfg_ready 1, cfg_err 0, in_ready 1, out_valid 0, out_vec 0, out_idx 0, out_last 0, busy 0, sweep_done 0.
- Evaluation latency: 1 cycle (accept at edge N → out_valid high after edge N).
- Throughput: 1 result/cycle with out_ready held high, both modes.
- Sweep with out_ready = 1 throughout: sweep_start at edge 0 → results idx 0..D-1 valid after edges 1..D; sweep_done high after edge D+1; busy low after edge D+1.
- Backpressure: out_vec, out_idx, out_last stable while out_valid && !out_ready.
- cfg_err: high for exactly one cycle after the offending accept edge.

## Test plan
- Reset then evaluate in_vec 4'hF with defaults → out_vec = 10'h000, out_idx = 4'hF, one cycle latency.
- Load func0 = 16'h8000, func1 = 16'hFFFE; evaluate 4'hF → out_vec[1:0] = 2'b11; evaluate 4'h0 → 2'b00; evaluate 4'h5 → 2'b10.
- Write cfg_func = 12 with OUT_N = 10 → cfg_err pulses one cycle, all tables unchanged; same-cycle write+evaluate returns old-table result.
- Load func9 = 16'h6996 (parity), sweep_start with out_ready = 1 → 16 results idx 0..15, out_vec[9] = parity(idx), out_last only on idx 15, sweep_done one cycle after.
- Sweep with out_ready toggled 1,0,0,1 repeating → no result lost or duplicated, outputs stable while stalled, cfg_ready and in_ready held 0 until return to IDLE.
- Assert rst_n low at sweep index 7 → out_valid, busy drop immediately, no sweep_done, tables read back as 0.

Source files
------------

// File: rtl/lut_bank.sv
// lut_bank: runtime-loadable bank of OUT_N truth tables over IN_W inputs,
// evaluated per request or by an exhaustive hardware sweep.
module lut_bank #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [4:0]             cfg_func,
  input  logic [(1<<IN_W)-1:0]   cfg_table,
  output logic                   cfg_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_vec,
  input  logic                   sweep_start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_N-1:0]       out_vec,
  output logic [IN_W-1:0]        out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   sweep_done
);

  localparam int D = 1 << IN_W;
  localparam logic [IN_W-1:0] LAST = IN_W'(D - 1);
  localparam logic [5:0] NF = 6'(OUT_N);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t state, state_nx;
  logic [IN_W-1:0] cnt, cnt_nx;
  logic [D-1:0] tbl [OUT_N];

  logic slot_free, eval_acc, cfg_acc;
  logic issue, sweep_issue, fin;
  logic [IN_W-1:0] issue_idx;
  logic [OUT_N-1:0] issue_vec;

  assign slot_free = !out_valid || out_ready;
  assign eval_acc  = in_valid && in_ready;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign issue     = eval_acc || sweep_issue;
  assign issue_idx = sweep_issue ? cnt : in_vec;
  assign busy      = state != IDLE;

  always_comb begin
    issue_vec = '0;
    for (int j = 0; j < OUT_N; j++)
      issue_vec[j] = tbl[j][issue_idx];
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    cfg_ready   = 1'b0;
    in_ready    = 1'b0;
    sweep_issue = 1'b0;
    fin         = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = !sweep_start && slot_free;
        if (sweep_start) begin
          cnt_nx   = '0;
          state_nx = SWEEP;
        end
      end
      SWEEP: begin
        if (slot_free) begin
          sweep_issue = 1'b1;
          if (cnt == LAST) state_nx = DONE;
          else             cnt_nx   = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_valid && out_ready && out_last) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sweep_done <= fin;
      cfg_err    <= cfg_acc && ({1'b0, cfg_func} >= NF);
    end
  end

  // Result is captured at issue so later table writes cannot alter it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_vec   <= issue_vec;
      out_idx   <= issue_idx;
      out_last  <= sweep_issue && (cnt == LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < OUT_N; j++)
        tbl[j] <= '0;
    end else begin
      for (int j = 0; j < OUT_N; j++)
        if (cfg_acc && cfg_func == 5'(j))
          tbl[j] <= cfg_table;
    end
  end

endmodule

// File: tb/tb_lut_bank.sv
// tb_lut_bank: directed stimulus with a queued scoreboard checked by a
// free-running output monitor.
module tb_lut_bank;

  logic clk = 0;
  logic rst_n = 0;
  logic cfg_valid = 0;
  logic cfg_ready;
  logic [4:0] cfg_func = 0;
  logic [15:0] cfg_table = 0;
  logic cfg_err;
  logic in_valid = 0;
  logic in_ready;
  logic [3:0] in_vec = 0;
  logic sweep_start = 0;
  logic out_valid;
  logic out_ready = 1;
  logic [9:0] out_vec;
  logic [3:0] out_idx;
  logic out_last;
  logic busy;
  logic sweep_done;

  lut_bank #(.IN_W(4), .OUT_N(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_func(cfg_func), .cfg_table(cfg_table), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .sweep_start(sweep_start),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic [9:0] vec;
    logic last;
  } res_t;

  res_t q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] tm [10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mdl(logic [3:0] i);
    logic [9:0] v;
    v = '0;
    for (int j = 0; j < 10; j++) v[j] = tm[j][i];
    return v;
  endfunction

  // Monitor: pops on every handshake, checks hold stability under stall
  logic held_v = 0;
  logic [9:0] h_vec;
  logic [3:0] h_idx;
  logic h_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 0;
    end else begin
      if (busy && (cfg_ready || in_ready))
        chk("ready_low_busy", {cfg_ready, in_ready}, 0);
      if (out_valid) begin
        if (held_v)
          chk("stall_stable", {h_last, h_idx, h_vec},
              {out_last, out_idx, out_vec});
        if (out_ready) begin
          held_v = 0;
          if (q.size() == 0) begin
            chk("unexpected_out", {out_idx, out_vec}, 32'hdead);
          end else begin
            res_t e;
            e = q.pop_front();
            chk("out_idx", out_idx, e.idx);
            chk("out_vec", out_vec, e.vec);
            chk("out_last", out_last, e.last);
          end
        end else begin
          held_v = 1;
          h_vec = out_vec;
          h_idx = out_idx;
          h_last = out_last;
        end
      end else begin
        held_v = 0;
      end
    end
  end

  task automatic cfg_write(input logic [4:0] f, input logic [15:0] t);
    cfg_valid = 1;
    cfg_func = f;
    cfg_table = t;
    @(posedge clk); #1;
    cfg_valid = 0;
    if (f < 10) tm[f] = t;
  endtask

  task automatic eval(input logic [3:0] v);
    bit done = 0;
    in_valid = 1;
    in_vec = v;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{idx: v, vec: mdl(v), last: 1'b0});
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!done) chk("eval_timeout", 0, 1);
    else chk("eval_latency", out_valid, 1);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 16; i++)
      q.push_back('{idx: 4'(i), vec: mdl(4'(i)), last: (i == 15)});
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int j = 0; j < 10; j++) tm[j] = '0;
    #3;
    chk("rst_outs", {cfg_ready, cfg_err, in_ready, out_valid, out_vec,
                     out_idx, out_last, busy, sweep_done},
        {1'b1, 1'b0, 1'b1, 1'b0, 10'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    eval(4'hF);
    chk("first_idx", out_idx, 4'hF);
    chk("first_vec", out_vec, 10'h000);

    cfg_write(5'd0, 16'h8000);
    cfg_write(5'd1, 16'hFFFE);
    eval(4'hF);
    chk("f01_F", out_vec[1:0], 2'b11);
    eval(4'h0);
    chk("f01_0", out_vec[1:0], 2'b00);
    eval(4'h5);
    chk("f01_5", out_vec[1:0], 2'b10);
    drain();

    cfg_write(5'd12, 16'hFFFF);
    chk("cfg_err_pulse", cfg_err, 1);
    @(posedge clk); #1;
    chk("cfg_err_once", cfg_err, 0);
    eval(4'hF);
    chk("bad_wr_dropped", out_vec, 10'h003);

    // same-cycle write and evaluate: evaluation sees the old table
    cfg_valid = 1;
    cfg_func = 5'd2;
    cfg_table = 16'hFFFF;
    in_valid = 1;
    in_vec = 4'h3;
    @(negedge clk);
    chk("same_cyc_rdy", {cfg_ready, in_ready}, 2'b11);
    q.push_back('{idx: 4'h3, vec: 10'h002, last: 1'b0});
    @(posedge clk); #1;
    cfg_valid = 0;
    in_valid = 0;
    tm[2] = 16'hFFFF;
    eval(4'h3);
    chk("new_tbl_vis", out_vec, 10'h006);
    drain();

    cfg_write(5'd9, 16'h6996);
    sweep_start = 1;
    push_sweep();
    @(posedge clk); #1;
    sweep_start = 0;
    chk("sweep_busy", busy, 1);
    repeat (16) @(posedge clk);
    #1;
    chk("sw_last_idx", {out_valid, out_last, out_idx}, {1'b1, 1'b1, 4'hF});
    chk("sw_par15", out_vec[9], 1'b0);
    chk("sw_done_early", {sweep_done, busy}, 2'b01);
    @(posedge clk); #1;
    chk("sw_done_pulse", {sweep_done, busy}, 2'b10);
    @(posedge clk); #1;
    chk("sw_done_once", sweep_done, 0);
    chk("sw_drained", q.size(), 0);

    // stalled sweep with out_ready pattern 1,0,0,1
    sweep_start = 1;
    push_sweep();
    @(posedge clk); #1;
    sweep_start = 0;
    begin
      int c;
      bit seen;
      seen = 0;
      c = 0;
      while (c < 300 && !seen) begin
        out_ready = (c % 4 == 0) || (c % 4 == 3);
        @(posedge clk); #1;
        if (sweep_done) seen = 1;
        c++;
      end
      chk("stall_sw_done", seen, 1);
    end
    out_ready = 1;
    chk("stall_idle", {busy, cfg_ready, in_ready}, 3'b011);
    chk("stall_drained", q.size(), 0);

    // reset in the middle of a sweep
    sweep_start = 1;
    push_sweep();
    @(posedge clk); #1;
    sweep_start = 0;
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
        if (out_valid && out_idx == 4'h7) hit = 1;
        else begin
          @(posedge clk); #1;
        end
      end
      chk("reach_idx7", hit, 1);
    end
    #1;
    rst_n = 0;
    #1;
    q.delete();
    chk("rst_mid", {out_valid, busy, sweep_done}, 3'b000);
    for (int j = 0; j < 10; j++) tm[j] = '0;
    @(posedge clk); #1;
    rst_n = 1;
    begin
      bit sd;
      sd = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (sweep_done || busy) sd = 1;
      end
      chk("no_sweep_done", sd, 0);
    end
    eval(4'hF);
    chk("clr_F", out_vec, 10'h000);
    eval(4'h5);
    chk("clr_5", out_vec, 10'h000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
